// File: rtl/fetch_stage_if.sv
// IF-stage bus: icache request/response, redirect/hazard inputs, IF/ID outputs.
// The master side is the fetch stage itself.
interface fetch_stage_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload_in;
  logic [31:0] imemload;
  logic [31:0] next_addr;
  logic        fd_enable;
  logic        fd_flush;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        halt;

  modport master (
    output imemREN, imemaddr, imemload, next_addr,
    output fd_enable, fd_flush,
    input  ihit, imemload_in, stall, redirect,
    input  redirect_addr, halt
  );

  modport slave (
    input  imemREN, imemaddr, imemload, next_addr,
    input  fd_enable, fd_flush,
    output ihit, imemload_in, stall, redirect,
    output redirect_addr, halt
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues icache reads, picks PC+4 or a redirect.
// Drains an in-flight miss before honouring a redirect; parks on halt.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } st_e;

  st_e         st_q, st_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        pend_halt_q, pend_halt_d;
  logic [31:0] tgt;
  logic        ren, fen, ffl;

  assign tgt = {bus.redirect_addr[31:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q        <= FETCH;
      pc_q        <= PC_INIT;
      pend_addr_q <= '0;
      pend_halt_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      pend_halt_q <= pend_halt_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    pend_halt_d = pend_halt_q;
    unique case (st_q)
      FETCH: begin
        if (bus.halt) begin
          if (bus.ihit) begin
            st_d = HALTED;
          end else begin
            pend_halt_d = 1'b1;
            st_d        = DRAIN;
          end
        end else if (bus.redirect) begin
          if (bus.ihit) begin
            pc_d = tgt;
          end else begin
            pend_addr_d = tgt;
            st_d        = DRAIN;
          end
        end else if (!bus.stall && bus.ihit) begin
          pc_d = pc_q + 32'd4;
        end
      end
      DRAIN: begin
        if (bus.redirect) pend_addr_d = tgt;
        if (bus.halt) pend_halt_d = 1'b1;
        // a redirect arriving with the hit is the newest target
        if (bus.ihit) begin
          if (pend_halt_q || bus.halt) begin
            st_d = HALTED;
          end else begin
            pc_d = bus.redirect ? tgt : pend_addr_q;
            st_d = FETCH;
          end
        end
      end
      HALTED: begin
      end
      default: st_d = FETCH;
    endcase
  end

  always_comb begin
    ren = 1'b0;
    fen = 1'b0;
    ffl = 1'b0;
    if (!RST) begin
      unique case (st_q)
        FETCH: begin
          ren = 1'b1;
          if (bus.halt || bus.redirect) begin
            fen = bus.ihit;
            ffl = bus.ihit;
          end else if (bus.stall) begin
            fen = 1'b0;
          end else begin
            fen = 1'b1;
            ffl = !bus.ihit;
          end
        end
        DRAIN: begin
          ren = 1'b1;
          fen = bus.ihit;
          ffl = bus.ihit;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.imemREN   = ren;
  assign bus.fd_enable = fen;
  assign bus.fd_flush  = ffl;
  assign bus.imemaddr  = pc_q;
  assign bus.next_addr = pc_q + 32'd4;
  assign bus.imemload  = bus.imemload_in;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations,
// then random traffic checked every cycle against a queue-based model.
module tb_fetch_stage;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_stage_if bus ();

  fetch_stage #(.PC_INIT(PC_INIT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // model: PC, pending targets in arrival order, halt flags
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic [31:0] mt;
  bit          m_halted, m_drain, m_ph, mvalid;

  initial begin
    m_pc = PC_INIT; m_halted = 0; m_drain = 0;
    m_ph = 0; mvalid = 0; mt = '0;
  end

  always @(posedge clk) begin
    mt = bus.redirect_addr & ~32'h3;
    if (rst) begin
      m_pc = PC_INIT; m_halted = 0; m_drain = 0;
      m_ph = 0; m_q.delete(); mvalid = 1;
    end else if (mvalid && !m_halted) begin
      if (m_drain) begin
        if (bus.redirect) m_q.push_back(mt);
        if (bus.halt) m_ph = 1;
        if (bus.ihit) begin
          m_drain = 0;
          if (m_ph) m_halted = 1;
          else begin
            m_pc = m_q[$];
            m_q.delete();
          end
        end
      end else if (bus.halt) begin
        if (bus.ihit) m_halted = 1;
        else begin m_ph = 1; m_drain = 1; end
      end else if (bus.redirect) begin
        if (bus.ihit) m_pc = mt;
        else begin m_q.push_back(mt); m_drain = 1; end
      end else if (!bus.stall && bus.ihit) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  function automatic logic [2:0] exp_ctl();
    // {imemREN, fd_enable, fd_flush}
    if (rst || m_halted) return 3'b000;
    if (m_drain) return bus.ihit ? 3'b111 : 3'b100;
    if (bus.halt || bus.redirect) return bus.ihit ? 3'b111 : 3'b100;
    if (bus.stall) return 3'b100;
    return bus.ihit ? 3'b110 : 3'b111;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      logic [2:0] e;
      e = exp_ctl();
      chk("imemREN", {31'd0, bus.imemREN}, {31'd0, e[2]});
      chk("fd_enable", {31'd0, bus.fd_enable}, {31'd0, e[1]});
      chk("fd_flush", {31'd0, bus.fd_flush}, {31'd0, e[0]});
      chk("imemaddr", bus.imemaddr, m_pc);
      chk("next_addr", bus.next_addr, m_pc + 32'd4);
      chk("imemload", bus.imemload, bus.imemload_in);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.imemload_in = $urandom;
  endtask

  task automatic go_to(input logic [31:0] a);
    bus.ihit = 1; bus.redirect = 1; bus.redirect_addr = a;
    bus.stall = 0; bus.halt = 0;
    tick();
    bus.redirect = 0;
  endtask

  initial begin
    bus.ihit = 0; bus.imemload_in = '0; bus.stall = 0;
    bus.redirect = 0; bus.redirect_addr = '0; bus.halt = 0;
    rst = 1;
    #2;
    chk("rst_ren", {31'd0, bus.imemREN}, 32'd0);
    chk("rst_en", {31'd0, bus.fd_enable}, 32'd0);
    tick();
    // sequential fetch from reset
    rst = 0; bus.ihit = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("seq_addr", bus.imemaddr, 32'(i * 4));
      chk("seq_next", bus.next_addr, 32'(i * 4 + 4));
      tick();
    end
    // stall holds PC at 0x10
    bus.stall = 1;
    #1 chk("stall_en", {31'd0, bus.fd_enable}, 32'd0);
    tick();
    #1 chk("stall_pc", bus.imemaddr, 32'h10);
    tick();
    bus.stall = 0;
    #1 chk("unstall_en", {31'd0, bus.fd_enable}, 32'd1);
    tick();
    #1 chk("unstall_pc", bus.imemaddr, 32'h14);
    chk("model_pc", m_pc, 32'h14);
    // redirect on a hit
    go_to(32'h20);
    bus.redirect = 1; bus.redirect_addr = 32'h103;
    #1 chk("redir_flush", {31'd0, bus.fd_flush}, 32'd1);
    tick();
    bus.redirect = 0;
    #1 chk("redir_pc", bus.imemaddr, 32'h100);
    // redirect during a miss, then newer redirect
    go_to(32'h40);
    bus.ihit = 0; bus.redirect = 1; bus.redirect_addr = 32'h200;
    #1 chk("miss_en", {31'd0, bus.fd_enable}, 32'd0);
    tick();
    bus.redirect = 0;
    tick();
    tick();
    bus.redirect = 1; bus.redirect_addr = 32'h300;
    #1 chk("drain_addr", bus.imemaddr, 32'h40);
    tick();
    bus.redirect = 0; bus.ihit = 1;
    #1 chk("drain_flush", {31'd0, bus.fd_flush}, 32'd1);
    tick();
    bus.ihit = 0;
    #1 chk("drain_pc", bus.imemaddr, 32'h300);
    // halt during a miss
    bus.halt = 1;
    tick();
    bus.halt = 0;
    #1 chk("halt_drain_ren", {31'd0, bus.imemREN}, 32'd1);
    bus.ihit = 1;
    #1 chk("halt_flush", {31'd0, bus.fd_flush}, 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.redirect = 1; bus.redirect_addr = $urandom;
      bus.ihit = 1'($urandom);
      #1 chk("halted_ren", {31'd0, bus.imemREN}, 32'd0);
      chk("halted_pc", bus.imemaddr, 32'h300);
      tick();
    end
    bus.redirect = 0; rst = 1;
    tick();
    rst = 0;
    #1 chk("rst_pc", bus.imemaddr, PC_INIT);
    // PC wrap
    go_to(32'hFFFF_FFFC);
    bus.ihit = 1;
    #1 chk("wrap_next", bus.next_addr, 32'h0);
    tick();
    #1 chk("wrap_pc", bus.imemaddr, 32'h0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst               = ($urandom_range(99) < 2);
      bus.ihit          = ($urandom_range(99) < 65);
      bus.redirect      = ($urandom_range(99) < 12);
      bus.stall         = ($urandom_range(99) < 15);
      bus.halt          = ($urandom_range(99) < 3);
      bus.redirect_addr = $urandom;
      tick();
    end
    rst = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
